// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, ALU control codes,
// ALUOp encodings and the ID/EX pipeline bundle.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [1:0]            alu_op;
    logic [2:0]            funct3;
    logic                  funct7_b5;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
  } id_ex_t;

endpackage

// File: rtl/alu_control_decode.sv
// ALUOp/funct3/funct7[5] -> 4-bit ALU control code (combinational).
// Ports: alu_op, funct3, funct7_b5 in; alu_control out.
module alu_control_decode
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_control
);

  logic rtype;

  assign rtype = (alu_op == ALUOP_RTYPE);

  always_comb begin
    alu_control = ALU_ILLEGAL;
    unique case (1'b1)
      (alu_op == ALUOP_MEM):
        alu_control = ALU_ADD;
      (alu_op == ALUOP_BRANCH):
        alu_control = ALU_SUB;
      (rtype && funct3 == F3_ADDSUB):
        alu_control = funct7_b5 ? ALU_SUB
                                : ALU_ADD;
      (rtype && funct3 == F3_AND):
        alu_control = ALU_AND;
      (rtype && funct3 == F3_OR):
        alu_control = ALU_OR;
      default:
        alu_control = ALU_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage feeding the ALU: one-entry valid/ready register,
// operand forwarding from EX/MEM and MEM/WB, ALU control decode.
// Ports: clk, rst (async, high); in_* decode side with in_valid/
// in_ready; flush; exm_*/mwb_* forwarding; out_valid/out_ready,
// x, y, alu_control, store_data, out_rd, out_* controls, illegal.
module alu_issue_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [1:0]            in_alu_op,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7_b5,
  input  logic                  in_alu_src,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_branch,
  input  logic                  flush,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [XLEN-1:0]       exm_result,
  input  logic                  mwb_reg_write,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]       mwb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       x,
  output logic [XLEN-1:0]       y,
  output logic [3:0]            alu_control,
  output logic [XLEN-1:0]       store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_branch,
  output logic                  illegal
);

  id_ex_t q;
  id_ex_t d;
  logic   vld;
  logic   cap;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  assign in_ready = !vld | out_ready;
  assign cap      = in_valid & in_ready & ~flush;

  assign d = '{
    rs1_data:  in_rs1_data,
    rs2_data:  in_rs2_data,
    imm:       in_imm,
    rs1:       in_rs1,
    rs2:       in_rs2,
    rd:        in_rd,
    alu_op:    in_alu_op,
    funct3:    in_funct3,
    funct7_b5: in_funct7_b5,
    alu_src:   in_alu_src,
    reg_write: in_reg_write,
    mem_read:  in_mem_read,
    mem_write: in_mem_write,
    branch:    in_branch
  };

  // Consume only clears vld when nothing new lands the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else begin
      if (flush)
        vld <= 1'b0;
      else if (cap)
        vld <= 1'b1;
      else if (out_ready)
        vld <= 1'b0;
      if (cap)
        q <= d;
    end
  end

  // EX/MEM is younger, so it wins; x0 is hard-wired zero.
  always_comb begin
    fwd_a = q.rs1_data;
    if (exm_reg_write && exm_rd != '0
        && exm_rd == q.rs1)
      fwd_a = exm_result;
    else if (mwb_reg_write && mwb_rd != '0
             && mwb_rd == q.rs1)
      fwd_a = mwb_result;

    fwd_b = q.rs2_data;
    if (exm_reg_write && exm_rd != '0
        && exm_rd == q.rs2)
      fwd_b = exm_result;
    else if (mwb_reg_write && mwb_rd != '0
             && mwb_rd == q.rs2)
      fwd_b = mwb_result;
  end

  alu_control_decode u_dec (
    .alu_op      (q.alu_op),
    .funct3      (q.funct3),
    .funct7_b5   (q.funct7_b5),
    .alu_control (alu_control)
  );

  assign out_valid     = vld;
  assign x             = fwd_a;
  assign y             = q.alu_src ? q.imm : fwd_b;
  assign store_data    = fwd_b;
  assign out_rd        = q.rd;
  assign out_reg_write = q.reg_write;
  assign out_mem_read  = q.mem_read;
  assign out_mem_write = q.mem_write;
  assign out_branch    = q.branch;
  assign illegal       = vld & (alu_control == ALU_ILLEGAL);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios
// plus a randomized run against a behavioural model.
module tb_alu_issue_stage;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        b5;
    logic        src;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  ins_t        drv;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [63:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd;
  logic [63:0] mwb_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] x;
  logic [63:0] y;
  logic [3:0]  alu_control;
  logic [63:0] store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_branch;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1_data   (drv.a),
    .in_rs2_data   (drv.b),
    .in_imm        (drv.imm),
    .in_rs1        (drv.rs1),
    .in_rs2        (drv.rs2),
    .in_rd         (drv.rd),
    .in_alu_op     (drv.op),
    .in_funct3     (drv.f3),
    .in_funct7_b5  (drv.b5),
    .in_alu_src    (drv.src),
    .in_reg_write  (drv.rw),
    .in_mem_read   (drv.mr),
    .in_mem_write  (drv.mw),
    .in_branch     (drv.br),
    .flush         (flush),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .x             (x),
    .y             (y),
    .alu_control   (alu_control),
    .store_data    (store_data),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .out_mem_read  (out_mem_read),
    .out_mem_write (out_mem_write),
    .out_branch    (out_branch),
    .illegal       (illegal)
  );

  function automatic logic [3:0] ref_ctrl(
    input logic [1:0] op,
    input logic [2:0] f3,
    input logic       b5
  );
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b1111;
    if (f3 == 3'd0) return b5 ? 4'b0110 : 4'b0010;
    if (f3 == 3'd7) return 4'b0000;
    if (f3 == 3'd6) return 4'b0001;
    return 4'b1111;
  endfunction

  function automatic logic [63:0] ref_fwd(
    input logic [4:0]  idx,
    input logic [63:0] data
  );
    if (idx == 0) return data;
    if (exm_reg_write && exm_rd == idx)
      return exm_result;
    if (mwb_reg_write && mwb_rd == idx)
      return mwb_result;
    return data;
  endfunction

  task automatic clear_drv();
    drv = '{a: 64'd0, b: 64'd0, imm: 64'd0,
           rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
           op: 2'd0, f3: 3'd0, b5: 1'b0,
           src: 1'b0, rw: 1'b0, mr: 1'b0,
           mw: 1'b0, br: 1'b0};
    in_valid      = 1'b0;
    flush         = 1'b0;
    exm_reg_write = 1'b0;
    exm_rd        = 5'd0;
    exm_result    = 64'd0;
    mwb_reg_write = 1'b0;
    mwb_rd        = 5'd0;
    mwb_result    = 64'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    clear_drv();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b want 1", in_ready);
    end
    n_cmp++;
    if (illegal !== 1'b0 || x !== 64'd0 || y !== 64'd0) begin
      n_err++;
      $display("FAIL reset_regs ill=%b x=%h y=%h want 0",
               illegal, x, y);
    end
    n_cmp++;
    if (alu_control !== 4'b0010 || out_rd !== 5'd0) begin
      n_err++;
      $display("FAIL reset_ctrl ctrl=%b rd=%0d want 0010/0",
               alu_control, out_rd);
    end
    rst = 1'b0;
  endtask

  task automatic test_rtype_add();
    @(posedge clk); #1;
    in_valid = 1'b1;
    drv.op = 2'b10; drv.f3 = 3'd0; drv.b5 = 1'b0;
    drv.rs1 = 5'd5; drv.a = 64'd7;
    drv.rs2 = 5'd6; drv.b = 64'd3;
    drv.rd = 5'd9; drv.rw = 1'b1; drv.src = 1'b0;
    drv.imm = 64'hABCD;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || x !== 64'd7 || y !== 64'd3
        || alu_control !== 4'b0010) begin
      n_err++;
      $display("FAIL rtype_add v=%b x=%0d y=%0d c=%b want 1/7/3/0010",
               out_valid, x, y, alu_control);
    end
    n_cmp++;
    if (out_rd !== 5'd9 || out_reg_write !== 1'b1
        || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL rtype_ctl rd=%0d rw=%b ill=%b want 9/1/0",
               out_rd, out_reg_write, illegal);
    end
  endtask

  task automatic test_forward();
    exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 64'h10;
    mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_result = 64'h20;
    #1;
    n_cmp++;
    if (x !== 64'h10) begin
      n_err++;
      $display("FAIL fwd_exm_prio got %h want 10", x);
    end
    exm_reg_write = 1'b0;
    #1;
    n_cmp++;
    if (x !== 64'h20) begin
      n_err++;
      $display("FAIL fwd_mwb got %h want 20", x);
    end
    exm_reg_write = 1'b1; exm_rd = 5'd0;
    mwb_rd = 5'd0;
    #1;
    n_cmp++;
    if (x !== 64'd7) begin
      n_err++;
      $display("FAIL fwd_x0 got %h want 7", x);
    end
    mwb_rd = 5'd6; mwb_result = 64'h55AA;
    #1;
    n_cmp++;
    if (y !== 64'h55AA || store_data !== 64'h55AA) begin
      n_err++;
      $display("FAIL fwd_rs2 y=%h sd=%h want 55aa", y, store_data);
    end
    clear_drv();
    drv.op = 2'b10; drv.rs1 = 5'd5; drv.a = 64'd7;
    drv.rs2 = 5'd6; drv.b = 64'd3;
    #1;
  endtask

  task automatic test_stall();
    @(posedge clk); #1;
    in_valid = 1'b1;
    drv.op = 2'b00; drv.rs1 = 5'd2; drv.a = 64'h111;
    drv.rs2 = 5'd3; drv.b = 64'h222; drv.imm = 64'h55;
    drv.src = 1'b1; drv.mr = 1'b1; drv.rd = 5'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1
          || x !== 64'd7 || y !== 64'd3) begin
        n_err++;
        $display("FAIL stall_hold%0d rdy=%b v=%b x=%h y=%h",
                 i, in_ready, out_valid, x, y);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || x !== 64'h111 || y !== 64'h55
        || store_data !== 64'h222 || out_mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL stall_new v=%b x=%h y=%h sd=%h mr=%b",
               out_valid, x, y, store_data, out_mem_read);
    end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    drv.rs1 = 5'd7; drv.a = 64'h999;
    drv.op = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || x !== 64'h111
        || alu_control !== 4'b0010) begin
      n_err++;
      $display("FAIL flush v=%b x=%h c=%b want 0/111/0010",
               out_valid, x, alu_control);
    end
  endtask

  task automatic test_decode();
    logic [1:0] ops [5];
    logic [2:0] f3s [5];
    logic [3:0] exp;
    ops = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10};
    f3s = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd1};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      drv.op = ops[k];
      drv.f3 = f3s[k];
      drv.b5 = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      exp = ref_ctrl(ops[k], f3s[k], 1'b0);
      n_cmp++;
      if (alu_control !== exp
          || illegal !== (exp == 4'b1111)) begin
        n_err++;
        $display("FAIL decode%0d c=%b ill=%b want %b",
                 k, alu_control, illegal, exp);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    ins_t hold;
    logic mv;
    logic [3:0] ec;
    logic [63:0] ex;
    logic [63:0] eb;
    int bad;
    rst = 1'b1;
    clear_drv();
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mv = 1'b0;
    hold = drv;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 9) == 0);
      drv.a = {$urandom, $urandom};
      drv.b = {$urandom, $urandom};
      drv.imm = {$urandom, $urandom};
      drv.rs1 = 5'($urandom_range(0, 3));
      drv.rs2 = 5'($urandom_range(0, 3));
      drv.rd = 5'($urandom);
      drv.op = 2'($urandom);
      drv.f3 = ($urandom_range(0, 1) == 0) ?
               3'($urandom) : 3'd0;
      drv.b5 = 1'($urandom);
      drv.src = 1'($urandom);
      drv.rw = 1'($urandom);
      drv.mr = 1'($urandom);
      drv.mw = 1'($urandom);
      drv.br = 1'($urandom);
      exm_reg_write = 1'($urandom);
      exm_rd = 5'($urandom_range(0, 3));
      exm_result = {$urandom, $urandom};
      mwb_reg_write = 1'($urandom);
      mwb_rd = 5'($urandom_range(0, 3));
      mwb_result = {$urandom, $urandom};
      @(negedge clk);
      ec = ref_ctrl(hold.op, hold.f3, hold.b5);
      ex = ref_fwd(hold.rs1, hold.a);
      eb = ref_fwd(hold.rs2, hold.b);
      n_cmp++;
      if (out_valid !== mv
          || in_ready !== (!mv || out_ready)
          || illegal !== (mv && ec == 4'b1111)) begin
        n_err++;
        bad++;
        if (bad < 10)
          $display("FAIL rnd_hs%0d v=%b rdy=%b ill=%b want v=%b",
                   i, out_valid, in_ready, illegal, mv);
      end
      if (mv) begin
        n_cmp++;
        if (x !== ex || store_data !== eb
            || y !== (hold.src ? hold.imm : eb)
            || alu_control !== ec || out_rd !== hold.rd
            || out_reg_write !== hold.rw
            || out_mem_read !== hold.mr
            || out_mem_write !== hold.mw
            || out_branch !== hold.br) begin
          n_err++;
          bad++;
          if (bad < 10)
            $display("FAIL rnd_data%0d x=%h/%h y=%h c=%b/%b",
                     i, x, ex, y, alu_control, ec);
        end
      end
      if (flush)
        mv = 1'b0;
      else if (in_valid && (!mv || out_ready)) begin
        mv = 1'b1;
        hold = drv;
      end else if (out_ready)
        mv = 1'b0;
    end
    clear_drv();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    in_valid = 1'b1;
    drv.op = 2'b10; drv.rs1 = 5'd1; drv.a = 64'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ar_setup v=%b rdy=%b want 1/0",
               out_valid, in_ready);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1
        || x !== 64'd0) begin
      n_err++;
      $display("FAIL async_reset v=%b rdy=%b x=%h want 0/1/0",
               out_valid, in_ready, x);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_forward();
    test_stall();
    test_flush();
    test_decode();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
